// File: rtl/ascii_case_stream_pkg.sv
// Shared definitions for the ASCII case stream: conversion modes and the
// character ranges that count as letters.
package ascii_case_stream_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  localparam logic [7:0] UPPER_LO = 8'h41;  // 'A'
  localparam logic [7:0] UPPER_HI = 8'h5A;  // 'Z'
  localparam logic [7:0] LOWER_LO = 8'h61;  // 'a'
  localparam logic [7:0] LOWER_HI = 8'h7A;  // 'z'

  // Upper and lower case letters differ only in this bit.
  localparam int CASE_BIT = 5;

  function automatic logic in_range(input logic [7:0] c,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/ascii_case_lane.sv
// One character lane: converts a byte according to the beat's mode and
// reports whether the byte was actually altered.
module ascii_case_lane
  import ascii_case_stream_pkg::*;
(
  input  logic [7:0] char_i,
  input  logic [1:0] mode_i,
  input  logic       keep_i,
  output logic [7:0] char_o,
  output logic       changed_o
);

  logic is_upper;
  logic is_lower;

  assign is_upper = in_range(char_i, UPPER_LO, UPPER_HI);
  assign is_lower = in_range(char_i, LOWER_LO, LOWER_HI);

  always_comb begin
    char_o = char_i;
    if (keep_i) begin
      case (mode_e'(mode_i))
        MODE_UPPER:  if (is_lower) char_o[CASE_BIT] = 1'b0;
        MODE_LOWER:  if (is_upper) char_o[CASE_BIT] = 1'b1;
        MODE_TOGGLE: if (is_upper || is_lower) char_o[CASE_BIT] = ~char_i[CASE_BIT];
        default:     char_o = char_i;
      endcase
    end
  end

  // Defined by comparison so pass mode and non-letters never count.
  assign changed_o = (char_o != char_i);

endmodule

// File: rtl/ascii_case_stream.sv
// Streaming ASCII case converter: LANES characters per beat through a single
// registered stage with valid/ready on both sides and a saturating change count.
module ascii_case_stream
  import ascii_case_stream_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic [LANES-1:0]   in_keep,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_keep,
  input  logic               cnt_clear,
  output logic [CNT_W-1:0]   conv_count
);

  localparam int POP_W = $clog2(LANES + 1);
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [8*LANES-1:0] conv_data;
  logic [LANES-1:0]   lane_changed;
  logic [POP_W-1:0]   pop_count;
  logic               accept;

  logic               out_valid_q, out_valid_d;
  logic [8*LANES-1:0] out_data_q,  out_data_d;
  logic [LANES-1:0]   out_keep_q,  out_keep_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W:0]     cnt_sum;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      ascii_case_lane u_lane (
        .char_i    (in_data[8*gi +: 8]),
        .mode_i    (mode),
        .keep_i    (in_keep[gi]),
        .char_o    (conv_data[8*gi +: 8]),
        .changed_o (lane_changed[gi])
      );
    end
  endgenerate

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_count = pop_count + POP_W'(lane_changed[i]);
    end
  end

  // The slot frees up in the same cycle the consumer takes the held beat.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = conv_data;
      out_keep_d  = in_keep;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear acts first so a clear with an accepted beat leaves just that beat's count.
  always_comb begin
    cnt_base = cnt_clear ? '0 : cnt_q;
    cnt_sum  = {1'b0, cnt_base} + (CNT_W + 1)'(pop_count);
    cnt_d    = cnt_base;
    if (accept) begin
      cnt_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign conv_count = cnt_q;

endmodule

// File: tb/tb_ascii_case_stream.sv
// Bench for ascii_case_stream: directed vector table, multi-cycle corner cases,
// and randomized traffic against a queue-based reference model.
module tb_ascii_case_stream;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, cnt_clear;
  logic [1:0]  mode;
  logic [31:0] in_data, out_data;
  logic [3:0]  in_keep, out_keep;
  logic [15:0] conv_count;

  logic        s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clear;
  logic [1:0]  s_mode;
  logic [31:0] s_in_data, s_out_data;
  logic [3:0]  s_in_keep, s_out_keep;
  logic [3:0]  s_conv_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ascii_case_stream #(.LANES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .cnt_clear(cnt_clear), .conv_count(conv_count)
  );

  ascii_case_stream #(.LANES(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(s_rst), .mode(s_mode), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_keep(s_in_keep), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_keep(s_out_keep), .cnt_clear(s_cnt_clear),
    .conv_count(s_conv_count)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic [3:0]  keep;
    logic [31:0] exp_data;
    int          exp_chg;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } beat_t;

  vec_t  vecs[8];
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Letter case by arithmetic on character codes: 'a'..'z' = 97..122, 'A'..'Z' = 65..90.
  function automatic logic [7:0] ref_char(input logic [1:0] m, input logic [7:0] c,
                                          input logic k);
    int v;
    bit lc, uc;
    v  = int'(c);
    lc = (v >= 97) && (v <= 122);
    uc = (v >= 65) && (v <= 90);
    if (!k) return c;
    case (m)
      2'd1: if (lc) v = v - 32;
      2'd2: if (uc) v = v + 32;
      2'd3: if (lc) v = v - 32; else if (uc) v = v + 32;
      default: ;
    endcase
    return v[7:0];
  endfunction

  initial begin
    int          exp_cnt;
    int          m_cnt;
    int          changes;
    bit          m_ready;
    beat_t       b;
    logic [7:0]  ch;
    logic [7:0]  oc;

    vecs[0] = '{2'd1, 32'h7A315A61, 4'hF, 32'h5A315A41, 2};
    vecs[1] = '{2'd3, 32'h5B404261, 4'hF, 32'h5B406241, 2};
    vecs[2] = '{2'd3, 32'h64636261, 4'h5, 32'h64436241, 2};
    vecs[3] = '{2'd2, 32'h5B5A4140, 4'hF, 32'h5B7A6140, 2};
    vecs[4] = '{2'd2, 32'hC17B6040, 4'hF, 32'hC17B6040, 0};
    vecs[5] = '{2'd0, 32'h42416261, 4'hF, 32'h42416261, 0};
    vecs[6] = '{2'd1, 32'h7A617B60, 4'hF, 32'h5A417B60, 2};
    vecs[7] = '{2'd1, 32'h64636261, 4'h0, 32'h64636261, 0};

    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_data = '0; in_keep = '0;
    out_ready = 1'b1; cnt_clear = 1'b0;
    s_rst = 1'b1; s_mode = 2'd0; s_in_valid = 1'b0; s_in_data = '0; s_in_keep = '0;
    s_out_ready = 1'b1; s_cnt_clear = 1'b0;
    tick(); tick();
    rst = 1'b0; s_rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_keep", out_keep, 0);
    chk("reset_count", conv_count, 0);

    // Directed vectors, one beat each with the consumer always ready.
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode; in_data = vecs[i].data; in_keep = vecs[i].keep;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      exp_cnt += vecs[i].exp_chg;
      $display("[TB] vec %0d mode=%0d in=%08h keep=%h -> out=%08h count=%0d",
               i, vecs[i].mode, vecs[i].data, vecs[i].keep, out_data, conv_count);
      chk("vec_out_valid", out_valid, 1);
      chk("vec_out_data", out_data, vecs[i].exp_data);
      chk("vec_out_keep", out_keep, vecs[i].keep);
      chk("vec_count", conv_count, exp_cnt);
      tick();
      chk("vec_no_dup", out_valid, 0);
    end

    // Backpressure: beat A held for three cycles, beat B must wait then follow.
    out_ready = 1'b0;
    mode = 2'd1; in_data = 32'h64636261; in_keep = 4'hF; in_valid = 1'b1;
    tick();
    exp_cnt += 4;
    mode = 2'd0; in_data = 32'h7A797877; in_keep = 4'h3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data_stable", out_data, 32'h44434241);
      chk("bp_out_keep_stable", out_keep, 4'hF);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    $display("[TB] backpressure release: out=%08h keep=%h count=%0d", out_data, out_keep, conv_count);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_data", out_data, 32'h7A797877);
    chk("bp_second_keep", out_keep, 4'h3);
    chk("bp_count", conv_count, exp_cnt);
    tick();
    chk("bp_no_dup", out_valid, 0);

    // Reset while a beat is stalled at the output.
    out_ready = 1'b0;
    mode = 2'd1; in_data = 32'h64636261; in_keep = 4'hF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_mid_pre_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("[TB] reset mid-transfer: out_valid=%0d count=%0d", out_valid, conv_count);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_count", conv_count, 0);
    chk("rst_mid_data", out_data, 0);
    out_ready = 1'b1;
    tick();
    chk("rst_mid_no_emit", out_valid, 0);

    // Saturation on the narrow-counter instance.
    s_mode = 2'd1; s_in_data = 32'h64636261; s_in_keep = 4'hF; s_in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      $display("[TB] sat beat %0d count=%0d", k, s_conv_count);
      chk("sat_count", s_conv_count, (4 * k > 15) ? 15 : 4 * k);
    end
    s_cnt_clear = 1'b1;
    tick();
    chk("sat_clear_with_accept", s_conv_count, 4);
    s_in_valid = 1'b0;
    tick();
    chk("sat_clear_alone", s_conv_count, 0);
    s_cnt_clear = 1'b0;

    // Randomized traffic against a queue model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cnt = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom_range(0, 3));
      in_keep   = 4'($urandom_range(0, 15));
      cnt_clear = ($urandom_range(0, 31) == 0);
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 3) == 0) ch = 8'($urandom_range(0, 255));
        else                           ch = 8'($urandom_range(8'h3E, 8'h7D));
        in_data[8*l +: 8] = ch;
      end
      #1;
      m_ready = (exp_q.size() == 0) || out_ready;
      chk("rnd_in_ready", in_ready, m_ready);
      chk("rnd_out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("rnd_out_data", out_data, exp_q[0].data);
        chk("rnd_out_keep", out_keep, exp_q[0].keep);
      end
      chk("rnd_count", conv_count, m_cnt);

      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (cnt_clear) m_cnt = 0;
      if (in_valid && m_ready) begin
        changes = 0;
        for (int l = 0; l < 4; l++) begin
          oc = ref_char(mode, in_data[8*l +: 8], in_keep[l]);
          b.data[8*l +: 8] = oc;
          if (oc != in_data[8*l +: 8]) changes++;
        end
        b.keep = in_keep;
        exp_q.push_back(b);
        m_cnt = (m_cnt + changes > 65535) ? 65535 : m_cnt + changes;
      end
      tick();
    end
    in_valid = 1'b0;
    cnt_clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
